bit_serializer: RTL and testbench

Parallel-to-serial front end for the serial pattern-detector path. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on `dout`, with `dout_valid` framing. It holds a one-word pending buffer so back-to-back words stream with no idle cycle between them. Between words it drives `dout` low, so the downstream detector sees 0 bits when the serializer is idle.

---
 rtl/bit_serializer.sv | 115 +++++++++++
 tb/tb_bit_serializer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word pending buffer so consecutive
// words stream with no idle cycle; dout is forced low whenever no word is shifting.
module bit_serializer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din_data,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             msb_first,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic [CNT_W-1:0] words_sent
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             dout_q;
    logic             dout_valid_q;
    logic             pend_valid_q;
    logic [CNT_W-1:0] words_q;
    logic [WIDTH-1:0] sh_q;
    logic             ord_q;
    logic [WIDTH-1:0] pend_q;
    logic             pend_ord_q;

    logic             accept;
    logic             final_bit;
    logic             shift_en;
    logic             load_en;
    logic             pend_wr;
    logic [WIDTH-1:0] word_d;
    logic             ord_d;

    function automatic logic first_bit(input logic [WIDTH-1:0] w, input logic o);
        return o ? w[WIDTH-1] : w[0];
    endfunction

    // Remaining bits stay aligned so the next bit is always at the same end.
    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w, input logic o);
        return o ? (w << 1) : (w >> 1);
    endfunction

    always_comb begin
        accept    = din_valid && !pend_valid_q;
        final_bit = (state_q == SHIFT) && (cnt_q == '0);
        shift_en  = (state_q == SHIFT) && (cnt_q != '0);
        pend_wr   = shift_en && accept;
        load_en   = ((state_q == IDLE) && accept) ||
                    (final_bit && (pend_valid_q || accept));
        // A pending word always wins over a fresh one on the final-bit edge.
        word_d    = pend_valid_q ? pend_q : din_data;
        ord_d     = pend_valid_q ? pend_ord_q : msb_first;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            pend_valid_q <= 1'b0;
            words_q      <= '0;
        end else begin
            if (final_bit) begin
                words_q <= words_q + CNT_W'(1);
            end
            if (load_en) begin
                state_q      <= SHIFT;
                dout_q       <= first_bit(word_d, ord_d);
                dout_valid_q <= 1'b1;
                cnt_q        <= CW'(WIDTH - 1);
                pend_valid_q <= 1'b0;
            end else if (shift_en) begin
                dout_q <= first_bit(sh_q, ord_q);
                cnt_q  <= cnt_q - CW'(1);
                if (pend_wr) begin
                    pend_valid_q <= 1'b1;
                end
            end else if (final_bit) begin
                state_q      <= IDLE;
                dout_q       <= 1'b0;
                dout_valid_q <= 1'b0;
            end
        end
    end

    // Word storage carries no reset: it is only observed through the control path.
    always_ff @(posedge clk) begin
        if (load_en) begin
            sh_q  <= shift_out(word_d, ord_d);
            ord_q <= ord_d;
        end else if (shift_en) begin
            sh_q <= shift_out(sh_q, ord_q);
        end
        if (pend_wr) begin
            pend_q     <= din_data;
            pend_ord_q <= msb_first;
        end
    end

    assign din_ready  = !pend_valid_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = dout_valid_q;
    assign words_sent = words_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench: accepted words are expanded into expected serial bits and
// checked cycle by cycle, together with handshake, framing and word count.
module tb_bit_serializer;

    localparam int W  = 8;
    localparam int CN = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din_data;
    logic         din_valid;
    logic         din_ready;
    logic         msb_first;
    logic         dout;
    logic         dout_valid;
    logic         busy;
    logic [CN-1:0] words_sent;

    typedef struct {
        logic b;
        logic last;
    } exp_bit_t;

    exp_bit_t q[$];
    int       n_checks = 0;
    int       n_errors = 0;
    int       exp_ws   = 0;
    logic     prev_last = 1'b0;

    bit_serializer #(.WIDTH(W), .CNT_W(CN)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_data   (din_data),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .msb_first  (msb_first),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    function automatic int words_in_q();
        int c = 0;
        foreach (q[i]) if (q[i].last) c++;
        return c;
    endfunction

    // Monitor: expected stream is the queue of not-yet-shown bits; any gap or
    // stray valid shows up as a dout_valid disagreement.
    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            exp_ws    = 0;
            prev_last = 1'b0;
            check("rst_dout", 32'(dout), 32'd0);
            check("rst_dout_valid", 32'(dout_valid), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_words_sent", 32'(words_sent), 32'd0);
            check("rst_din_ready", 32'(din_ready), 32'd1);
        end else begin
            exp_bit_t e;
            if (prev_last) exp_ws = (exp_ws + 1) % (1 << CN);
            prev_last = 1'b0;
            check("words_sent", 32'(words_sent), 32'(exp_ws));
            check("dout_valid", 32'(dout_valid), 32'(q.size() != 0));
            check("busy", 32'(busy), 32'(q.size() != 0));
            check("din_ready", 32'(din_ready), 32'(words_in_q() < 2));
            if (q.size() != 0) begin
                e = q.pop_front();
                check("dout_bit", 32'(dout), 32'(e.b));
                prev_last = e.last;
            end else begin
                check("dout_idle_low", 32'(dout), 32'd0);
            end
        end
    end

    // Offer one word; returns just after the accepting edge with din_valid dropped
    // and the other inputs scrambled (must not affect the word in flight).
    task automatic offer(input logic [W-1:0] d, input logic o);
        logic r;
        din_data  = d;
        msb_first = o;
        din_valid = 1'b1;
        for (int t = 0; t < 4 * W; t++) begin
            @(negedge clk);
            r = din_ready;
            @(posedge clk);
            if (r) begin
                for (int i = 0; i < W; i++) begin
                    exp_bit_t e;
                    e.b    = o ? d[W-1-i] : d[i];
                    e.last = (i == W - 1);
                    q.push_back(e);
                end
                #1;
                din_valid = 1'b0;
                din_data  = W'($urandom);
                msb_first = 1'($urandom);
                return;
            end
        end
        n_checks++;
        n_errors++;
        $display("FAIL accept_timeout at %0t: word %0h never accepted", $time, d);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        din_data  = '0;
        din_valid = 1'b0;
        msb_first = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        idle(2);

        offer(8'hAA, 1'b1);
        idle(12);
        offer(8'h55, 1'b0);
        idle(12);
        offer(8'hAA, 1'b1);
        offer(8'h0F, 1'b1);
        idle(20);
        offer(8'hAA, 1'b1);
        offer(8'h0F, 1'b1);
        offer(8'h33, 1'b0);
        idle(30);

        // Reset mid-word with a word pending.
        offer(8'hC3, 1'b1);
        offer(8'h5A, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        idle(12);

        for (int n = 0; n < 200; n++) begin
            offer(W'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 12));
        end

        for (int t = 0; t < 40 && q.size() != 0; t++) @(posedge clk);
        if (q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: %0d bits never emitted", q.size());
        end
        idle(4);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
